// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle control unit.
// Opcodes, funct codes, mux selects, ALU ops, state codes.
package cpu_defs;

  localparam logic [31:0] SP_INIT = 32'd227;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] IORD_PC     = 3'd0;
  localparam logic [2:0] IORD_EXC    = 3'd1;
  localparam logic [2:0] IORD_ALUOUT = 3'd2;

  localparam logic [2:0] SRCA_PC = 3'd0;
  localparam logic [2:0] SRCA_A  = 3'd1;

  localparam logic [2:0] SRCB_B    = 3'd0;
  localparam logic [2:0] SRCB_FOUR = 3'd1;
  localparam logic [2:0] SRCB_SEXT = 3'd2;
  localparam logic [2:0] SRCB_SHL  = 3'd3;

  localparam logic [2:0] PCS_ALU    = 3'd0;
  localparam logic [2:0] PCS_ALUOUT = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_LOAD   = 3'd3;

  localparam logic [2:0] WR_RT = 3'd0;
  localparam logic [2:0] WR_RD = 3'd1;
  localparam logic [2:0] WR_SP = 3'd2;
  localparam logic [2:0] WR_RA = 3'd3;

  localparam logic [3:0] WD_ALUOUT = 4'd0;
  localparam logic [3:0] WD_LOAD   = 4'd1;
  localparam logic [3:0] WD_SP     = 4'd2;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [2:0] EXC_OPC = 3'd0;
  localparam logic [2:0] EXC_OVF = 3'd1;

  localparam logic [1:0] LS_WORD = 2'd0;
  localparam logic [1:0] LS_BYTE = 2'd2;

  typedef enum logic [5:0] {
    S_RESET      = 6'd0,
    S_FETCH      = 6'd1,
    S_DECODE     = 6'd2,
    S_R_EXEC     = 6'd3,
    S_R_WB       = 6'd4,
    S_ADDI       = 6'd5,
    S_ADDI_WB    = 6'd6,
    S_MEM_ADDR   = 6'd7,
    S_LW_READ    = 6'd8,
    S_LW_WB      = 6'd9,
    S_SW_WRITE   = 6'd10,
    S_BRANCH     = 6'd11,
    S_JUMP       = 6'd12,
    S_EXC_OPCODE = 6'd13,
    S_EXC_OVF    = 6'd14,
    S_EXC_READ   = 6'd15,
    S_EXC_JUMP   = 6'd16
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       load_a;
    logic       load_b;
    logic       aluout_load;
    logic       epc_write;
    logic [2:0] iord;
    logic [2:0] ex_cause;
    logic [2:0] wr_reg;
    logic [2:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] pc_source;
    logic [2:0] alu_op;
    logic [3:0] wd_reg;
    logic [1:0] load_ctrl;
    logic [1:0] store_ctrl;
    logic       sing_ex_ctrl;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the control unit and the cpu datapath.
// master = control unit, slave = datapath.
interface control_unit_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       Overflow;
  logic       PcWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       Load_A;
  logic       Load_B;
  logic       ALUout_Load;
  logic       EPCwrite;
  logic [2:0] IorD;
  logic [2:0] ExCause;
  logic [2:0] WR_REG;
  logic [2:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] PcSource;
  logic [2:0] ALUOp;
  logic [3:0] WD_REG;
  logic [1:0] LoadCtrl;
  logic [1:0] StoreCtrl;
  logic       SingExCtrl;
  logic [5:0] state_dbg;

  modport master (
    input  OP, Funct, Zero, Overflow,
    output PcWrite, IRWrite, RegWrite, MemWrite,
    output Load_A, Load_B, ALUout_Load, EPCwrite,
    output IorD, ExCause, WR_REG, ALUSrcA, ALUSrcB,
    output PcSource, ALUOp, WD_REG,
    output LoadCtrl, StoreCtrl, SingExCtrl, state_dbg
  );

  modport slave (
    output OP, Funct, Zero, Overflow,
    input  PcWrite, IRWrite, RegWrite, MemWrite,
    input  Load_A, Load_B, ALUout_Load, EPCwrite,
    input  IorD, ExCause, WR_REG, ALUSrcA, ALUSrcB,
    input  PcSource, ALUOp, WD_REG,
    input  LoadCtrl, StoreCtrl, SingExCtrl, state_dbg
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM for the cpu datapath.
// Outputs are registered alongside the state; branch PcWrite is Zero-gated.
module control_unit
  import cpu_defs::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LAST_F = CW'(MEM_WAIT);
  localparam logic [CW-1:0] LAST_R = CW'(MEM_WAIT - 1);

  state_t        state, ns;
  logic          hold;
  logic [CW-1:0] cnt, ncnt;
  logic [2:0]    exc_q, exc_d;
  ctrl_t         out_q, out_d;
  logic          r_ok, r_is_and, br_take;

  // Funct classification for R-type dispatch and overflow masking
  always_comb begin
    r_ok = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB)
        || (bus.Funct == FN_AND);
    r_is_and = (bus.Funct == FN_AND);
  end

  // Next-state, wait counter and exception cause selection
  always_comb begin
    ns = state;
    unique case (state)
      S_RESET:  ns = hold ? S_RESET : S_FETCH;
      S_FETCH:  if (cnt == LAST_F) ns = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (bus.OP == OP_RTYPE) && r_ok: ns = S_R_EXEC;
          bus.OP == OP_ADDI:            ns = S_ADDI;
          bus.OP == OP_LW:              ns = S_MEM_ADDR;
          bus.OP == OP_SW:              ns = S_MEM_ADDR;
          bus.OP == OP_BEQ:             ns = S_BRANCH;
          bus.OP == OP_BNE:             ns = S_BRANCH;
          bus.OP == OP_J:               ns = S_JUMP;
          default:                      ns = S_EXC_OPCODE;
        endcase
      end
      S_R_EXEC:
        ns = (bus.Overflow && !r_is_and) ? S_EXC_OVF : S_R_WB;
      S_ADDI:
        ns = bus.Overflow ? S_EXC_OVF : S_ADDI_WB;
      S_MEM_ADDR:
        ns = (bus.OP == OP_SW) ? S_SW_WRITE : S_LW_READ;
      S_LW_READ:  if (cnt == LAST_R) ns = S_LW_WB;
      S_EXC_READ: if (cnt == LAST_R) ns = S_EXC_JUMP;
      S_EXC_OPCODE, S_EXC_OVF: ns = S_EXC_READ;
      S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE,
      S_BRANCH, S_JUMP, S_EXC_JUMP: ns = S_FETCH;
      default: ns = S_RESET;
    endcase
    ncnt = (ns == state) ? cnt + CW'(1) : '0;
    exc_d = exc_q;
    if (ns == S_EXC_OVF) exc_d = EXC_OVF;
    if (ns == S_EXC_OPCODE) exc_d = EXC_OPC;
  end

  // Control word for the state being entered
  always_comb begin
    out_d = '0;
    unique case (ns)
      S_RESET: begin
        out_d.reg_write = 1'b1;
        out_d.wr_reg    = WR_SP;
        out_d.wd_reg    = WD_SP;
      end
      S_FETCH: begin
        out_d.iord      = IORD_PC;
        out_d.alu_src_a = SRCA_PC;
        out_d.alu_src_b = SRCB_FOUR;
        out_d.alu_op    = ALU_ADD;
        if (ncnt == LAST_F) begin
          out_d.ir_write  = 1'b1;
          out_d.pc_write  = 1'b1;
          out_d.pc_source = PCS_ALU;
        end
      end
      S_DECODE: begin
        out_d.load_a      = 1'b1;
        out_d.load_b      = 1'b1;
        out_d.alu_src_a   = SRCA_PC;
        out_d.alu_src_b   = SRCB_SHL;
        out_d.alu_op      = ALU_ADD;
        out_d.aluout_load = 1'b1;
      end
      S_R_EXEC: begin
        out_d.alu_src_a   = SRCA_A;
        out_d.alu_src_b   = SRCB_B;
        out_d.aluout_load = 1'b1;
        unique case (1'b1)
          bus.Funct == FN_SUB: out_d.alu_op = ALU_SUB;
          bus.Funct == FN_AND: out_d.alu_op = ALU_AND;
          default:             out_d.alu_op = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        out_d.reg_write = 1'b1;
        out_d.wr_reg    = WR_RD;
        out_d.wd_reg    = WD_ALUOUT;
      end
      S_ADDI, S_MEM_ADDR: begin
        out_d.alu_src_a   = SRCA_A;
        out_d.alu_src_b   = SRCB_SEXT;
        out_d.alu_op      = ALU_ADD;
        out_d.aluout_load = 1'b1;
      end
      S_ADDI_WB: begin
        out_d.reg_write = 1'b1;
        out_d.wr_reg    = WR_RT;
        out_d.wd_reg    = WD_ALUOUT;
      end
      S_LW_READ: out_d.iord = IORD_ALUOUT;
      S_LW_WB: begin
        out_d.reg_write = 1'b1;
        out_d.wr_reg    = WR_RT;
        out_d.wd_reg    = WD_LOAD;
        out_d.load_ctrl = LS_WORD;
      end
      S_SW_WRITE: begin
        out_d.iord       = IORD_ALUOUT;
        out_d.mem_write  = 1'b1;
        out_d.store_ctrl = LS_WORD;
      end
      S_BRANCH: begin
        out_d.alu_src_a = SRCA_A;
        out_d.alu_src_b = SRCB_B;
        out_d.alu_op    = ALU_SUB;
        out_d.pc_source = PCS_ALUOUT;
      end
      S_JUMP: begin
        out_d.pc_source = PCS_JUMP;
        out_d.pc_write  = 1'b1;
      end
      S_EXC_OPCODE, S_EXC_OVF: begin
        out_d.alu_src_a = SRCA_PC;
        out_d.alu_src_b = SRCB_FOUR;
        out_d.alu_op    = ALU_SUB;
        out_d.epc_write = 1'b1;
        out_d.ex_cause  = exc_d;
      end
      S_EXC_READ: begin
        out_d.iord     = IORD_EXC;
        out_d.ex_cause = exc_d;
      end
      S_EXC_JUMP: begin
        out_d.load_ctrl = LS_BYTE;
        out_d.pc_source = PCS_LOAD;
        out_d.pc_write  = 1'b1;
      end
      default: out_d = '0;
    endcase
  end

  // State, counter and registered control word
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_RESET;
      hold  <= 1'b1;
      cnt   <= '0;
      exc_q <= EXC_OPC;
      out_q <= '0;
    end else begin
      state <= ns;
      hold  <= 1'b0;
      cnt   <= ncnt;
      exc_q <= exc_d;
      out_q <= out_d;
    end
  end

  // beq takes on Zero, bne on not-Zero
  always_comb begin
    br_take = (state == S_BRANCH)
           && ((bus.OP == OP_BNE) ? !bus.Zero : bus.Zero);
  end

  assign bus.PcWrite     = out_q.pc_write | br_take;
  assign bus.IRWrite     = out_q.ir_write;
  assign bus.RegWrite    = out_q.reg_write;
  assign bus.MemWrite    = out_q.mem_write;
  assign bus.Load_A      = out_q.load_a;
  assign bus.Load_B      = out_q.load_b;
  assign bus.ALUout_Load = out_q.aluout_load;
  assign bus.EPCwrite    = out_q.epc_write;
  assign bus.IorD        = out_q.iord;
  assign bus.ExCause     = out_q.ex_cause;
  assign bus.WR_REG      = out_q.wr_reg;
  assign bus.ALUSrcA     = out_q.alu_src_a;
  assign bus.ALUSrcB     = out_q.alu_src_b;
  assign bus.PcSource    = out_q.pc_source;
  assign bus.ALUOp       = out_q.alu_op;
  assign bus.WD_REG      = out_q.wd_reg;
  assign bus.LoadCtrl    = out_q.load_ctrl;
  assign bus.StoreCtrl   = out_q.store_ctrl;
  assign bus.SingExCtrl  = out_q.sing_ex_ctrl;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit.
// Walks each instruction class and the reset/exception corners.
module tb_control_unit;

  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  control_unit_if bus();

  control_unit #(.MEM_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    for (int i = 0; i <= MW; i++) begin
      step();
      check("fetch_state", 32'(bus.state_dbg), 1);
      check("fetch_irw", 32'(bus.IRWrite), (i == MW) ? 1 : 0);
      check("fetch_pcw", 32'(bus.PcWrite), (i == MW) ? 1 : 0);
      check("fetch_memw", 32'(bus.MemWrite), 0);
      check("fetch_regw", 32'(bus.RegWrite), 0);
    end
  endtask

  task automatic decode();
    step();
    check("dec_state", 32'(bus.state_dbg), 2);
    check("dec_loada", 32'(bus.Load_A), 1);
    check("dec_srcb", 32'(bus.ALUSrcB), 3);
    check("dec_aluld", 32'(bus.ALUout_Load), 1);
  endtask

  task automatic exc_tail(input logic [2:0] cause);
    for (int i = 0; i < MW; i++) begin
      step();
      check("excrd_state", 32'(bus.state_dbg), 15);
      check("excrd_iord", 32'(bus.IorD), 1);
      check("excrd_cause", 32'(bus.ExCause), 32'(cause));
      check("excrd_regw", 32'(bus.RegWrite), 0);
    end
    step();
    check("excj_state", 32'(bus.state_dbg), 16);
    check("excj_pcs", 32'(bus.PcSource), 3);
    check("excj_pcw", 32'(bus.PcWrite), 1);
    check("excj_ldc", 32'(bus.LoadCtrl), 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.OP = 6'h00;
    bus.Funct = 6'h00;
    bus.Zero = 1'b0;
    bus.Overflow = 1'b0;

    repeat (3) begin
      step();
      check("rst_state", 32'(bus.state_dbg), 0);
      check("rst_pcw", 32'(bus.PcWrite), 0);
      check("rst_regw", 32'(bus.RegWrite), 0);
    end
    reset = 1'b1;
    step();
    check("rel_state", 32'(bus.state_dbg), 0);
    check("rel_regw", 32'(bus.RegWrite), 1);
    check("rel_wr", 32'(bus.WR_REG), 2);
    check("rel_wd", 32'(bus.WD_REG), 2);
    check("rel_pcw", 32'(bus.PcWrite), 0);

    // add
    bus.OP = 6'h00; bus.Funct = 6'h20;
    fetch(); decode();
    step();
    check("add_state", 32'(bus.state_dbg), 3);
    check("add_op", 32'(bus.ALUOp), 1);
    check("add_srca", 32'(bus.ALUSrcA), 1);
    check("add_regw", 32'(bus.RegWrite), 0);
    step();
    check("addwb_state", 32'(bus.state_dbg), 4);
    check("addwb_regw", 32'(bus.RegWrite), 1);
    check("addwb_wr", 32'(bus.WR_REG), 1);
    check("addwb_wd", 32'(bus.WD_REG), 0);

    // sub overflowing
    bus.Funct = 6'h22; bus.Overflow = 1'b1;
    fetch(); decode();
    step();
    check("sub_op", 32'(bus.ALUOp), 2);
    step();
    check("subovf_state", 32'(bus.state_dbg), 14);
    check("subovf_cause", 32'(bus.ExCause), 1);
    check("subovf_epc", 32'(bus.EPCwrite), 1);
    check("subovf_regw", 32'(bus.RegWrite), 0);
    exc_tail(3'd1);

    // and ignores overflow
    bus.Funct = 6'h24;
    fetch(); decode();
    step();
    check("and_op", 32'(bus.ALUOp), 3);
    step();
    check("andwb_state", 32'(bus.state_dbg), 4);
    check("andwb_regw", 32'(bus.RegWrite), 1);
    bus.Overflow = 1'b0;

    // beq
    bus.OP = 6'h04; bus.Zero = 1'b1;
    fetch(); decode();
    step();
    check("beq_state", 32'(bus.state_dbg), 11);
    check("beq_pcw1", 32'(bus.PcWrite), 1);
    check("beq_pcs", 32'(bus.PcSource), 1);
    check("beq_op", 32'(bus.ALUOp), 2);
    bus.Zero = 1'b0;
    #1;
    check("beq_pcw0", 32'(bus.PcWrite), 0);

    // bne
    bus.OP = 6'h05; bus.Zero = 1'b1;
    fetch(); decode();
    step();
    check("bne_pcw0", 32'(bus.PcWrite), 0);
    bus.Zero = 1'b0;
    #1;
    check("bne_pcw1", 32'(bus.PcWrite), 1);

    // j
    bus.OP = 6'h02;
    fetch(); decode();
    step();
    check("j_state", 32'(bus.state_dbg), 12);
    check("j_pcs", 32'(bus.PcSource), 2);
    check("j_pcw", 32'(bus.PcWrite), 1);

    // lw
    bus.OP = 6'h23;
    fetch(); decode();
    step();
    check("lw_addr", 32'(bus.state_dbg), 7);
    check("lw_srcb", 32'(bus.ALUSrcB), 2);
    for (int i = 0; i < MW; i++) begin
      step();
      check("lwrd_state", 32'(bus.state_dbg), 8);
      check("lwrd_iord", 32'(bus.IorD), 2);
    end
    step();
    check("lwwb_state", 32'(bus.state_dbg), 9);
    check("lwwb_regw", 32'(bus.RegWrite), 1);
    check("lwwb_wd", 32'(bus.WD_REG), 1);
    check("lwwb_wr", 32'(bus.WR_REG), 0);

    // sw
    bus.OP = 6'h2B;
    fetch(); decode();
    step();
    check("sw_addr", 32'(bus.state_dbg), 7);
    step();
    check("sw_state", 32'(bus.state_dbg), 10);
    check("sw_memw", 32'(bus.MemWrite), 1);
    check("sw_iord", 32'(bus.IorD), 2);

    // invalid opcode
    bus.OP = 6'h3F;
    fetch(); decode();
    step();
    check("inv_state", 32'(bus.state_dbg), 13);
    check("inv_epc", 32'(bus.EPCwrite), 1);
    check("inv_cause", 32'(bus.ExCause), 0);
    check("inv_regw", 32'(bus.RegWrite), 0);
    exc_tail(3'd0);

    // addi overflowing
    bus.OP = 6'h08; bus.Overflow = 1'b1;
    fetch(); decode();
    step();
    check("addi_state", 32'(bus.state_dbg), 5);
    step();
    check("addiovf_state", 32'(bus.state_dbg), 14);
    check("addiovf_cause", 32'(bus.ExCause), 1);
    check("addiovf_regw", 32'(bus.RegWrite), 0);
    exc_tail(3'd1);
    bus.Overflow = 1'b0;

    // unknown funct
    bus.OP = 6'h00; bus.Funct = 6'h21;
    fetch(); decode();
    step();
    check("badfn_state", 32'(bus.state_dbg), 13);
    exc_tail(3'd0);

    // reset during sw write
    bus.OP = 6'h2B;
    fetch(); decode();
    step();
    step();
    check("swr_memw", 32'(bus.MemWrite), 1);
    reset = 1'b0;
    step();
    check("swr_state", 32'(bus.state_dbg), 0);
    check("swr_memw0", 32'(bus.MemWrite), 0);
    check("swr_regw0", 32'(bus.RegWrite), 0);
    reset = 1'b1;
    step();
    check("swr_rel", 32'(bus.RegWrite), 1);
    step();
    check("swr_fetch", 32'(bus.state_dbg), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
